// File: rtl/result_msg_packer_pkg.sv
// Message layout for the PC link, framing FSM encoding and shared helpers.
package result_msg_packer_pkg;

    localparam logic [3:0] TAG_FRAME_START = 4'h1;
    localparam logic [3:0] TAG_PIXEL       = 4'h3;
    localparam logic [3:0] TAG_FRAME_END   = 4'h4;

    localparam int ROW_W   = 12;
    localparam int COL_W   = 11;
    localparam int FRAME_W = 20;
    localparam int PIX_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // Ceiling log2, used for pointer widths.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic logic [63:0] pack_frame_start(input logic [FRAME_W-1:0] frame);
        return {40'd0, frame, TAG_FRAME_START};
    endfunction

    function automatic logic [63:0] pack_pixel(input logic [ROW_W-1:0] row,
                                               input logic [COL_W-1:0] col,
                                               input logic [PIX_W-1:0] pix);
        return {pix, col, row, 5'd0, TAG_PIXEL};
    endfunction

    function automatic logic [63:0] pack_frame_end(input logic [ROW_W-1:0]   rows,
                                                   input logic [FRAME_W-1:0] frame);
        return {28'd0, frame, rows, TAG_FRAME_END};
    endfunction

endpackage

// File: rtl/result_msg_packer_msg_fifo.sv
// Single-clock FIFO buffering packed messages against host back-pressure.
module result_msg_packer_msg_fifo
    import result_msg_packer_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow
);

    localparam int AW = log2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == {(AW+1){1'b0}});
    assign o_overflow = i_wr_en & o_full;
    assign w_do_wr    = i_wr_en & ~o_full;
    assign w_do_rd    = i_rd_en & ~o_empty;
    assign o_rd_data  = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Pointers and occupancy; a write dropped on full leaves them untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1'b1);
                2'b01:   r_count <= r_count - (AW+1)'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_msg_packer.sv
// Frames the dark-subtracted pixel stream into tagged 64-bit host messages
// (frame start, per-pixel with row/col, frame end) through a small buffer.
module result_msg_packer
    import result_msg_packer_pkg::*;
#(
    parameter int XB_SIZE      = 64,
    parameter int FP_SIZE      = 32,
    parameter int N_FRAME_SIZE = 20,
    parameter int N_ROW_MAX    = 2064,
    parameter int N_COL_MAX    = 2048,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    dram_clk,
    input  logic                    reset,
    input  logic                    pixel_valid,
    input  logic [FP_SIZE-1:0]      pixel,
    input  logic                    fval,
    input  logic                    lval,
    input  logic                    fpga_msg_full,
    output logic                    fpga_msg_valid,
    output logic [XB_SIZE-1:0]      fpga_msg,
    output logic                    error,
    output logic [N_FRAME_SIZE-1:0] frame_count
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_fval_d;
    logic                    r_lval_d;
    logic [ROW_W-1:0]        r_row;
    logic [ROW_W-1:0]        w_row_nxt;
    logic [ROW_W-1:0]        w_row_inc;
    logic [COL_W:0]          r_col;
    logic [COL_W:0]          w_col_nxt;
    logic [N_FRAME_SIZE-1:0] r_frame_count;
    logic                    w_fc_inc;
    logic                    r_error;
    logic                    r_msg_valid;
    logic [XB_SIZE-1:0]      r_msg;
    logic                    w_push;
    logic [XB_SIZE-1:0]      w_push_word;
    logic [XB_SIZE-1:0]      w_fifo_head;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_overflow;
    logic                    w_pop;
    logic                    w_fval_rise;
    logic                    w_fval_fall;
    logic                    w_lval_rise;
    logic                    w_lval_fall;
    logic                    w_proto_err;
    logic [FRAME_W-1:0]      w_frame_no;
    logic [PIX_W-1:0]        w_pix;

    assign w_fval_rise = fval & ~r_fval_d;
    assign w_fval_fall = ~fval & r_fval_d;
    assign w_lval_rise = lval & ~r_lval_d;
    assign w_lval_fall = ~lval & r_lval_d;
    assign w_proto_err = (pixel_valid & ~lval) | (w_fval_fall & lval);
    assign w_frame_no  = FRAME_W'(r_frame_count);
    assign w_pix       = PIX_W'(pixel);
    assign w_row_inc   = r_row + 12'd1;
    assign w_pop       = ~w_fifo_empty & ~fpga_msg_full;

    // Framing decisions: next state, counter updates and the single word to push.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_push_word  = {XB_SIZE{1'b0}};
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_fc_inc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_proto_err || (w_fval_rise && lval)) begin
                    w_next_state = ST_ERROR;
                end else if (w_fval_rise) begin
                    w_push       = 1'b1;
                    w_push_word  = pack_frame_start(w_frame_no);
                    w_row_nxt    = 12'd0;
                    w_next_state = ST_FRAME;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (w_proto_err) begin
                    w_next_state = ST_ERROR;
                end else if (w_fval_fall) begin
                    w_push       = 1'b1;
                    w_push_word  = pack_frame_end(r_row, w_frame_no);
                    w_fc_inc     = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_lval_rise && (r_row == ROW_W'(N_ROW_MAX))) begin
                    w_next_state = ST_ERROR;
                end else if (w_lval_rise) begin
                    // The first pixel of a line may arrive together with the lval edge.
                    w_next_state = ST_LINE;
                    w_push       = pixel_valid;
                    w_push_word  = pack_pixel(r_row, 11'd0, w_pix);
                    w_col_nxt    = pixel_valid ? 12'd1 : 12'd0;
                end else begin
                    w_next_state = ST_FRAME;
                end
            end
            ST_LINE: begin
                if (w_proto_err) begin
                    w_next_state = ST_ERROR;
                end else if (w_lval_fall && w_fval_fall) begin
                    w_push       = 1'b1;
                    w_push_word  = pack_frame_end(w_row_inc, w_frame_no);
                    w_row_nxt    = w_row_inc;
                    w_fc_inc     = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_lval_fall) begin
                    w_row_nxt    = w_row_inc;
                    w_next_state = ST_FRAME;
                end else if (pixel_valid && (r_col == (COL_W+1)'(N_COL_MAX))) begin
                    w_next_state = ST_ERROR;
                end else if (pixel_valid) begin
                    w_push      = 1'b1;
                    w_push_word = pack_pixel(r_row, r_col[COL_W-1:0], w_pix);
                    w_col_nxt   = r_col + 12'd1;
                end else begin
                    w_next_state = ST_LINE;
                end
            end
            ST_ERROR: begin
                w_next_state = ST_ERROR;
            end
            default: begin
                w_next_state = ST_ERROR;
            end
        endcase
    end

    // State, counters and edge history; an overflowing push wins over normal framing.
    always_ff @(posedge dram_clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_fval_d      <= 1'b0;
            r_lval_d      <= 1'b0;
            r_row         <= 12'd0;
            r_col         <= 12'd0;
            r_frame_count <= {N_FRAME_SIZE{1'b0}};
            r_error       <= 1'b0;
        end else if (w_overflow) begin
            r_fval_d <= fval;
            r_lval_d <= lval;
            r_state  <= ST_ERROR;
            r_error  <= 1'b1;
        end else begin
            r_fval_d <= fval;
            r_lval_d <= lval;
            r_state  <= w_next_state;
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_error  <= (w_next_state == ST_ERROR);
            if (w_fc_inc) r_frame_count <= r_frame_count + N_FRAME_SIZE'(1'b1);
        end
    end

    // Registered host write port, loaded from the buffer head on each pop.
    always_ff @(posedge dram_clk) begin
        if (reset) begin
            r_msg_valid <= 1'b0;
            r_msg       <= {XB_SIZE{1'b0}};
        end else begin
            r_msg_valid <= w_pop;
            if (w_pop) r_msg <= w_fifo_head;
        end
    end

    result_msg_packer_msg_fifo #(
        .WIDTH (XB_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_msg_fifo (
        .i_clk      (dram_clk),
        .i_reset    (reset),
        .i_wr_en    (w_push),
        .i_wr_data  (w_push_word),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_fifo_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_overflow (w_overflow)
    );

    assign fpga_msg_valid = r_msg_valid;
    assign fpga_msg       = r_msg;
    assign error          = r_error;
    assign frame_count    = r_frame_count;

endmodule

// File: doc/result_msg_packer.md
# result_msg_packer

Packs the dark-subtracted float pixel stream into XB_SIZE-bit messages for the PC link. Sits directly downstream of the frame processing stage: it consumes the fsub result stream and delayed FVAL/LVAL, and drives fpga_msg/fpga_msg_valid into the host-bound FIFO. It stamps every pixel with row and column and brackets each frame with start and end messages. A small internal FIFO absorbs back-pressure from fpga_msg_full.

## Interface
Parameters:
- XB_SIZE, 64: message width; must be 64.
- FP_SIZE, 32: float pixel width; must be ≤ 32.
- N_FRAME_SIZE, 20: frame counter width.
- N_ROW_MAX, 2064: rows per frame.
- N_COL_MAX, 2048: columns per line.
- FIFO_DEPTH, 16: internal buffer depth; power of 2, ≥ 4.

Ports:
- Clocking (already decided): one clock, dram_clk; reset is synchronous and active-high, named reset.
- dram_clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- pixel_valid, in, 1: pixel is valid this cycle (fsub rdy).
- pixel, in, FP_SIZE: dark-subtracted float.
- fval, in, 1: frame valid, aligned to pixel_valid.
- lval, in, 1: line valid, aligned to pixel_valid.
- fpga_msg_full, in, 1: host FIFO cannot accept a write.
- fpga_msg_valid, out, 1: write strobe for one message (registered).
- fpga_msg, out, XB_SIZE: message word (registered).
- error, out, 1: sticky error.
- frame_count, out, N_FRAME_SIZE: frames completed since reset.

## Operation
Message formats use bit 0 as the LSB.

- Tag field is [3:0].
- FRAME_START, tag 4'h1:
  - [23:4] frame number.
  - Other bits 0.
- PIXEL, tag 4'h3:
  - [8:4] 0.
  - [20:9] row (12b).
  - [31:21] col (11b).
  - [63:32] pixel, zero-extended to 32b.
- FRAME_END, tag 4'h4:
  - [15:4] rows seen.
  - [35:16] frame number.
  - Other bits 0.

State machine, cur_state ∈ {IDLE, FRAME, LINE, ERROR}:
- IDLE:
  - fval rising with lval=0 and pixel_valid=0: push FRAME_START(frame_count), row←0, go to FRAME.
  - fval rising with lval=1 or pixel_valid=1: go to ERROR.
- FRAME:
  - lval rising: col←0, go to LINE.
  - fval falling: push FRAME_END(row, frame_count), frame_count++, go to IDLE.
- LINE:
  - Each pixel_valid: push PIXEL(row, col, pixel), col++.
  - lval falling: row++, go to FRAME.
- ERROR: absorbing until reset.
- Conditions that send any state to ERROR:
  - pixel_valid with lval=0.
  - fval falling while lval=1.
  - col reaching N_COL_MAX when a pixel arrives (a 2049th pixel).
  - row reaching N_ROW_MAX on lval rising.
  - A push while the internal FIFO is full (overflow).
- At most one word is pushed per cycle by construction; a push and a pop in the same cycle are both honored.
- In ERROR: no pushes; the FIFO keeps draining to the host.

## Timing
- Reset values:
  - fpga_msg_valid=0, fpga_msg=0, error=0, frame_count=0.
  - State IDLE, FIFO empty.
  - row, col and all edge-detect registers 0. Edge detectors are cleared, so fval high at reset release counts as a rising edge.
- Push latency: event at cycle t, word written into the FIFO at the t edge, visible at the FIFO head at t+1.
- Pop rule: pop at cycle t iff FIFO is non-empty and fpga_msg_full=0 at t. Then fpga_msg_valid=1 and fpga_msg=head at t+1.
- Minimum input-to-output latency is 2 cycles.
- Throughput: one message per cycle when not back-pressured.
- The host FIFO must deassert capacity with at least 1 word of margin, i.e. fpga_msg_full is a prog_full.
- error rises the cycle after the offending event and stays high until reset.
- Reset mid-frame: everything is discarded and the next fval rise starts frame 0.

## Structure
- Shared include msg_format.vh: tag localparams and field offsets/widths, also used by the PC-side decoder testbench model.
- Uses log2 from function.v.
- One sub-module, msg_fifo: synchronous FIFO, one clock, parameterized width/depth, with full, empty and overflow outputs.
- Framing FSM and counters stay in result_msg_packer.
- Estimated total 200–300 lines.

## Test plan
- Single frame, 2 rows × 3 pixels, fpga_msg_full=0 → 8 words in order:
  - FRAME_START(0).
  - PIXEL(r0,c0..2).
  - PIXEL(r1,c0..2).
  - FRAME_END(rows=2, frame=0).
  - frame_count=1.
  - First word 2 cycles after the fval edge.
- Back-pressure: hold fpga_msg_full=1 for 10 cycles during a 12-pixel line with FIFO_DEPTH=16 → no loss, no error, every word emitted exactly once in order after release.
- Overflow: fpga_msg_full=1 for 20 pixels, FIFO_DEPTH=16 → error=1 one cycle after the 17th push. The 16 buffered words still drain after release.
- Protocol: pixel_valid with lval=0 inside a frame → error; fval falling with lval=1 → error.
- Column limit: 2049 pixels in one line → error on the 2049th. Exactly 2048 pixels → no error and last col=2047.
- Reset mid-line, then a new frame → FRAME_START frame number 0, row 0, col 0.
